// File: rtl/sn74ls195a_pkg.sv
// ---------------------------------------------------------------------------
// sn74ls195a_pkg
//
// Purpose : shared types and constants for the SN74LS195A shift sequencer.
//           Holds the controller state enum, the PE mode encodings seen by
//           the external register, and the serial-fill encodings that select
//           what gets shifted into Q0 behind the outgoing word.
//
// Contents:
//   state_t         controller state (IDLE waits for a word, SHIFT emits it)
//   PE_LOAD         PE level that makes the register load Q <= P
//   PE_SHIFT        PE level that makes the register shift toward Q3
//   FILL_ZERO/ONE   serial fill selections (J=K=0 clears Q0, J=K=1 sets Q0)
//   BITS_PER_WORD   number of serial bits per loaded nibble
//   LAST_CNT        counter value while the final bit (din[0]) is on sout
//   fill_jk()       J/K drive level for a given fill selection
// ---------------------------------------------------------------------------
package sn74ls195a_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic PE_LOAD  = 1'b0;
  localparam logic PE_SHIFT = 1'b1;

  localparam logic FILL_ZERO = 1'b0;
  localparam logic FILL_ONE  = 1'b1;

  localparam int unsigned BITS_PER_WORD = 4;
  localparam logic [1:0]  LAST_CNT      = 2'(BITS_PER_WORD - 1);

  // The chip's K input is really K-bar, so tying J and K together to the
  // same level turns the JK stage into a plain D input: both low clears
  // Q0, both high sets it.  One level therefore drives both pins.
  function automatic logic fill_jk(input logic fill);
    return fill;
  endfunction

endpackage

// File: rtl/sn74ls195a_shift_sequencer.sv
// ---------------------------------------------------------------------------
// sn74ls195a_shift_sequencer
//
// Purpose : drives an external SN74LS195A 4-bit shift register (same CP) as
//           a parallel-to-serial transmitter.  A nibble accepted on the din
//           valid/ready port is parallel-loaded into the chip, then shifted
//           out MSB-first (Q3) on the sout valid/ready port.  When the
//           consumer stalls, the register is held by reloading its own Q
//           outputs through P, so no clock gating is needed.
//
// Parameters:
//   FILL        value shifted into Q0 behind the word (0 -> J=K=0, 1 -> J=K=1)
//
// Ports:
//   CP          in   clock, shared with the register chip
//   MR          in   asynchronous active-high reset (chip MR is driven from ~MR
//                    outside this block)
//   din         in   [3:0] word to transmit
//   din_valid   in   din is valid
//   din_ready   out  din will be loaded at the next CP edge
//   Q           in   [3:0] register outputs Q3..Q0
//   P           out  [3:0] register parallel inputs
//   PE          out  register mode (0 = parallel load, 1 = shift)
//   J, K        out  register serial inputs, tied to FILL
//   sout        out  serial data bit (Q3)
//   sout_valid  out  sout is valid
//   sout_ready  in   consumer accepts sout this cycle
//   sout_last   out  current sout is bit 0 of the word
//   busy        out  controller is in SHIFT
// ---------------------------------------------------------------------------
module sn74ls195a_shift_sequencer
  import sn74ls195a_pkg::*;
#(
  parameter logic FILL = FILL_ZERO
) (
  input  logic       CP,
  input  logic       MR,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [3:0] Q,
  output logic [3:0] P,
  output logic       PE,
  output logic       J,
  output logic       K,
  output logic       sout,
  output logic       sout_valid,
  input  logic       sout_ready,
  output logic       sout_last,
  output logic       busy
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // State and bit counter.  MR throws away any word in flight at once; the
  // chip is cleared by the same reset, so the two stay in step.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and register-control decode.  Every chip control acts at the
  // next CP edge, so this is purely combinational from state, cnt, Q and the
  // two handshake inputs.  The default is "reload Q through P", which is the
  // safe hold for the chip in every situation that is not an explicit load
  // of din or an accepted shift, including while MR is asserted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    PE         = PE_LOAD;
    P          = Q;
    din_ready  = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;

    if (!MR) begin
      unique case (state_q)
        IDLE: begin
          din_ready = 1'b1;
          if (din_valid) begin
            P       = din;
            state_d = SHIFT;
            cnt_d   = 2'd0;
          end
        end

        SHIFT: begin
          sout_valid = 1'b1;
          sout_last  = (cnt_q == LAST_CNT);
          // A stalled cycle leaves PE at load with P=Q, so Q, sout and cnt
          // all repeat.  din_valid is deliberately not looked at here, and
          // the return to IDLE on the last shift means a new word can only
          // be loaded one cycle after sout_last.
          if (sout_ready) begin
            PE    = PE_SHIFT;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_CNT) begin
              state_d = IDLE;
              cnt_d   = 2'd0;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // The bit on the wire is always the chip's Q3; sout_valid qualifies it.
  assign sout = Q[3];

  // J and K only matter on shift edges, but they are held constant so the
  // fill value is never a function of state.
  assign J = fill_jk(FILL);
  assign K = fill_jk(FILL);

  assign busy = (state_q == SHIFT);

endmodule

// File: doc/sn74ls195a_shift_sequencer.md
# sn74ls195a_shift_sequencer

Controller that sequences an external SN74LS195A 4-bit shift register as a parallel-to-serial transmitter. Accepts a nibble on a valid/ready input port and drives PE/P/J/K to load it. Shifts it out MSB-first on a valid/ready serial port, holding the register by self-reload whenever the consumer stalls. Sits beside the SN74LS195A gate or behavioral model, on the same CP.

## Interface
- FILL, default 0: serial fill value shifted into Q0. 0 gives J=0,K=0; 1 gives J=1,K=1.
- CP  in  1  clock; all state changes on rising edge.
- MR  in  1  reset, asynchronous, active-high. The register chip's own active-low MR is driven from ~MR at top level, not by this block.
- din  in  4  word to transmit.
- din_valid  in  1  din is valid.
- din_ready  out  1  block will load din at next CP edge.
- Q  in  4  register outputs Q3..Q0.
- P  out  4  register parallel inputs.
- PE  out  1  register mode: 0 = parallel load, 1 = shift.
- J, K  out  1 each  register serial inputs.
- sout  out  1  serial data bit.
- sout_valid  out  1  sout is valid.
- sout_ready  in  1  consumer accepts sout this cycle.
- sout_last  out  1  current sout is bit 0 of the word.
- busy  out  1  state is SHIFT.

## Operation
- State register values: IDLE, SHIFT. 2-bit counter cnt.
- Register semantics: a CP edge with PE=0 loads Q<=P. With PE=1, Q0 <= JK function, Q1<=Q0, Q2<=Q1, Q3<=Q2.
- Emission order is therefore Q3 first, i.e. din[3], din[2], din[1], din[0].
- IDLE:
  - din_ready=1, sout_valid=0, PE=0.
  - P=din if din_valid, else P=Q (hold by reload).
  - din_valid=1: go SHIFT, cnt=0.
- SHIFT:
  - sout=Q[3], sout_valid=1, sout_last=(cnt==3), din_ready=0.
  - sout_ready=1: PE=1, J=K=FILL. cnt increments; at cnt==3, go IDLE with cnt=0.
  - sout_ready=0: PE=0, P=Q (hold), cnt and state unchanged.
- J=K=FILL at all times. They are don't-care to the register when PE=0, but are driven constant.
- PE, P, sout, sout_valid, sout_last and din_ready are combinational from state, cnt, Q, din_valid and sout_ready. They act at the next CP edge.
- din_valid during SHIFT is ignored. No back-to-back load on the same edge as the last shift.
- After a full word with FILL=0, Q=0000; with FILL=1, Q=1111.

## Timing
- Reset (MR=1, asynchronous): state=IDLE, cnt=0. Outputs while MR=1: din_ready=0, sout_valid=0, sout_last=0, busy=0, PE=0, P=Q, J=K=FILL.
- Release of MR takes effect at the first CP edge after deassertion.
- MR asserted mid-word: the word is discarded immediately. No sout_last is produced for it.
- Load latency: the din handshake at edge n makes Q valid after edge n. The first sout_valid is in the cycle after edge n.
- Zero-stall throughput: 1 load cycle plus 4 shift cycles, so 5 CP cycles per word.
- Stall: each cycle with sout_ready=0 in SHIFT adds exactly one cycle. Q, sout and cnt are held; sout_valid stays 1.
- sout_valid never drops in SHIFT before the last handshake.

## Structure
- Package sn74ls195a_pkg holds:
  - state enum {IDLE, SHIFT};
  - constants PE_LOAD=0 and PE_SHIFT=1;
  - FILL encodings.
- Single module. The 2-bit counter stays inline; no sub-module is needed.
- The bench pairs this block with SN74LS195Abehavior, with MR_chip=~MR, closing the Q-to-P loop.

## Test plan
- Reset then idle: MR=1 for 12 ns, then release. Required: din_ready=0 during reset, Q=0000 held for 10 cycles with PE=0, sout_valid=0.
- Single word, no stall: din=1010, sout_ready=1, FILL=0. Required: sout sequence 1,0,1,0, sout_last on the 4th bit, Q=0000 afterwards, 5 cycles total.
- Stall hold: din=0110, sout_ready low for 3 cycles after the second bit. Required: sout stays at 1 and Q stays at 1000 throughout the stall; output sequence 0,1,1,0; total 8 cycles.
- Fill=1: din=0001, no stall. Required: sout 0,0,0,1, then Q=1111 in IDLE.
- Reset mid-word: din=1100, MR pulsed after the first bit. Required: state=IDLE immediately, no sout_last; a following word 0011 emits 0,0,1,1 correctly.
- Ignored input: din_valid held high with alternating din during SHIFT. Required: the emitted word is unaffected; the next load occurs only in the cycle after sout_last.
